// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline register with a valid/ready handshake, a 2-entry skid buffer and a synchronous flush.
// IN_READY comes straight from a flop, so the upstream ready path is fully registered.
module pipe_stage_skid_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic [CTRL_W-1:0] IN_CTRL,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CTRL_W-1:0] OUT_CTRL,
  output logic [1:0]        COUNT
);

  // state   | meaning
  // S_EMPTY | no word held, OUT_VALID=0
  // S_ONE   | main entry holds the word on OUT_*
  // S_TWO   | main and skid full, upstream held off
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              in_ready_q;
  logic              in_fire, out_fire;
  logic              load_main_in, load_main_skid, load_skid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = (state != S_EMPTY);
  assign in_fire   = IN_VALID & in_ready_q;
  assign out_fire  = OUT_VALID & OUT_READY;
  assign OUT_DATA  = main_data;
  assign OUT_CTRL  = OUT_VALID ? main_ctrl : '0;
  assign COUNT     = 2'(state);

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (FLUSH) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (in_fire) begin
            state_nxt    = S_ONE;
            load_main_in = 1'b1;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            state_nxt = S_TWO;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          if (out_fire) begin
            state_nxt      = S_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != S_TWO);
    end
  end

  // Data is not cleared on flush: OUT_DATA keeps its last value while empty.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main_in) begin
        main_data <= IN_DATA;
        main_ctrl <= IN_CTRL;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (load_skid) begin
        skid_data <= IN_DATA;
        skid_ctrl <= IN_CTRL;
      end
    end
  end

endmodule
